// File: rtl/mac_bias_slice_pkg.sv
// Shared width/latency helpers for the mac_bias_slice block.
// Whether the bias is added is decided in the top file by MAC_BIAS_SLICE_BIAS_EN.
package mac_bias_slice_pkg;

    // Width of a full product plus one guard bit.
    function automatic int num_width(input int img_w, input int ker_w);
        return img_w + ker_w + 1;
    endfunction

    function automatic int tree_levels(input int group_nb);
        return (group_nb > 1) ? $clog2(group_nb) : 0;
    endfunction

    // Cycles from val&last at the input to the result_val pulse.
    function automatic int latency(input int group_nb);
        return 5 + tree_levels(group_nb);
    endfunction

    localparam int DEFAULT_GROUP_NB = 4;
    localparam int DEFAULT_LATENCY  = latency(DEFAULT_GROUP_NB);

endpackage

// File: rtl/mac_bias_slice_sum_tree.sv
// Pipelined binary adder tree: one register level per halving, clog2(GROUP_NB) cycles.
// Lane count is padded with zeros up to the next power of two.
module sum_tree
    import mac_bias_slice_pkg::*;
#(
    parameter int GROUP_NB  = 4,
    parameter int NUM_WIDTH = 33
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_val,
    input  logic [GROUP_NB*NUM_WIDTH-1:0] in_data,
    output logic                          out_val,
    output logic [NUM_WIDTH-1:0]          out_data
);

    localparam int LEVELS = tree_levels(GROUP_NB);
    localparam int P      = 1 << LEVELS;

    logic [P-1:0][NUM_WIDTH-1:0] leaf;

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < GROUP_NB) begin : g_used
                assign leaf[gi] = in_data[gi*NUM_WIDTH +: NUM_WIDTH];
            end else begin : g_pad
                assign leaf[gi] = '0;
            end
        end

        for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
            localparam int N = P >> (gi + 1);
            logic [2*N-1:0][NUM_WIDTH-1:0] src;
            logic                          src_val;
            logic [N-1:0][NUM_WIDTH-1:0]   sum_reg;
            logic                          val_reg;

            if (gi == 0) begin : g_first
                assign src     = leaf;
                assign src_val = in_val;
            end else begin : g_next
                assign src     = g_lvl[gi-1].sum_reg;
                assign src_val = g_lvl[gi-1].val_reg;
            end

            always_ff @(posedge clk) begin
                if (rst) val_reg <= 1'b0;
                else     val_reg <= src_val;
                for (int i = 0; i < N; i++) begin
                    sum_reg[i] <= src[2*i] + src[2*i+1];
                end
            end
        end

        if (LEVELS == 0) begin : g_passthru
            assign out_data = leaf[0];
            assign out_val  = in_val;
        end else begin : g_out
            assign out_data = g_lvl[LEVELS-1].sum_reg[0];
            assign out_val  = g_lvl[LEVELS-1].val_reg;
        end
    endgenerate

endmodule

// File: rtl/mac_bias_slice.sv
// Windowed multi-lane signed MAC with adder-tree reduction and a final bias stage.
// Define MAC_BIAS_SLICE_BIAS_EN to add bias; otherwise the bias port is ignored (same latency).
module mac_bias_slice
    import mac_bias_slice_pkg::*;
#(
    parameter int  GROUP_NB  = 4,
    parameter int  IMG_WIDTH = 16,
    parameter int  KER_WIDTH = 16,
    localparam int NUM_WIDTH = num_width(IMG_WIDTH, KER_WIDTH)
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] img,
    input  logic [GROUP_NB*KER_WIDTH-1:0] ker,
    input  logic                          val,
    input  logic                          last,
    input  logic signed [NUM_WIDTH-1:0]   bias,
    output logic signed [NUM_WIDTH-1:0]   result,
    output logic                          result_val
);

    logic [GROUP_NB*IMG_WIDTH-1:0]      img_reg;
    logic [GROUP_NB*KER_WIDTH-1:0]      ker_reg;
    logic                               s1_val_reg, s1_last_reg;
    logic [GROUP_NB-1:0][NUM_WIDTH-1:0] prod_next, prod_reg;
    logic                               s2_val_reg, s2_last_reg;
    logic [GROUP_NB-1:0][NUM_WIDTH-1:0] acc_next, acc_reg;
    logic                               first_reg, s3_done_reg;
    logic [GROUP_NB-1:0][NUM_WIDTH-1:0] hold_reg;
    logic                               hold_val_reg;
    logic [NUM_WIDTH-1:0]               tree_sum;
    logic                               tree_val;
    logic [NUM_WIDTH-1:0]               result_next;

    genvar gi;
    generate
        for (gi = 0; gi < GROUP_NB; gi++) begin : g_lane
            logic [IMG_WIDTH-1:0]        img_lane;
            logic [KER_WIDTH-1:0]        ker_lane;
            logic signed [NUM_WIDTH-1:0] img_ext, ker_ext;

            assign img_lane = img_reg[gi*IMG_WIDTH +: IMG_WIDTH];
            assign ker_lane = ker_reg[gi*KER_WIDTH +: KER_WIDTH];
            assign img_ext  = {{(NUM_WIDTH-IMG_WIDTH){img_lane[IMG_WIDTH-1]}}, img_lane};
            assign ker_ext  = {{(NUM_WIDTH-KER_WIDTH){ker_lane[KER_WIDTH-1]}}, ker_lane};
            // Exact product fits in IMG+KER bits, so the truncated multiply is exact.
            assign prod_next[gi] = img_ext * ker_ext;
            assign acc_next[gi]  = first_reg ? prod_reg[gi] : acc_reg[gi] + prod_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        img_reg  <= img;
        ker_reg  <= ker;
        prod_reg <= prod_next;
        if (rst) begin
            s1_val_reg   <= 1'b0;
            s1_last_reg  <= 1'b0;
            s2_val_reg   <= 1'b0;
            s2_last_reg  <= 1'b0;
            acc_reg      <= '0;
            first_reg    <= 1'b1;
            s3_done_reg  <= 1'b0;
            hold_reg     <= '0;
            hold_val_reg <= 1'b0;
        end else begin
            s1_val_reg   <= val;
            s1_last_reg  <= val & last;
            s2_val_reg   <= s1_val_reg;
            s2_last_reg  <= s1_last_reg;
            if (s2_val_reg) begin
                acc_reg   <= acc_next;
                first_reg <= s2_last_reg;
            end
            s3_done_reg  <= s2_val_reg & s2_last_reg;
            // The next window may overwrite acc_reg this same edge; hold keeps the finished sums.
            if (s3_done_reg) hold_reg <= acc_reg;
            hold_val_reg <= s3_done_reg;
        end
    end

    sum_tree #(
        .GROUP_NB  (GROUP_NB),
        .NUM_WIDTH (NUM_WIDTH)
    ) u_sum_tree (
        .clk      (clk),
        .rst      (rst),
        .in_val   (hold_val_reg),
        .in_data  (hold_reg),
        .out_val  (tree_val),
        .out_data (tree_sum)
    );

`ifdef MAC_BIAS_SLICE_BIAS_EN
    assign result_next = tree_sum + bias;
`else
    logic unused_bias;
    assign unused_bias = ^bias;
    assign result_next = tree_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= '0;
            result_val <= 1'b0;
        end else begin
            result_val <= tree_val;
            if (tree_val) result <= result_next;
        end
    end

endmodule

// File: tb/tb_mac_bias_slice.sv
// Directed bench for mac_bias_slice (GROUP_NB=4, 16x16): reset, windows, signed, back-to-back, abort.
// Expected results follow MAC_BIAS_SLICE_BIAS_EN when the bench is built with it.
module tb_mac_bias_slice;

    localparam int NW = 33;
`ifdef MAC_BIAS_SLICE_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [63:0]          img, ker;
    logic                 val, last;
    logic signed [NW-1:0] bias;
    logic signed [NW-1:0] result;
    logic                 result_val;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    int lat;
    int pulses_before;
    longint exp_val;

    always #5 clk = ~clk;

    mac_bias_slice #(
        .GROUP_NB  (4),
        .IMG_WIDTH (16),
        .KER_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .img        (img),
        .ker        (ker),
        .val        (val),
        .last       (last),
        .bias       (bias),
        .result     (result),
        .result_val (result_val)
    );

    always @(posedge clk) if (result_val === 1'b1) pulse_cnt++;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [63:0] i, input logic [63:0] k, input logic v, input logic l);
        @(negedge clk);
        img = i; ker = k; val = v; last = l;
    endtask

    // Waits for the next result_val, counting cycles since the last drive; -1 on timeout.
    task automatic wait_pulse(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin val = 1'b0; last = 1'b0; end
            if (result_val === 1'b1) begin cycles = c; break; end
        end
    endtask

    initial begin
        rst = 1'b1; img = '0; ker = '0; val = 1'b0; last = 1'b0; bias = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 0);
        chk("reset_val", {63'd0, result_val}, 0);
        rst = 1'b0;
        $display("step reset: result=%0d result_val=%0b", result, result_val);

        // Single-sample window: 5+12+21+32 = 70, plus bias 10
        bias = 10;
        drv(64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 1'b1, 1'b1);
        wait_pulse(lat);
        exp_val = BIAS_ON ? 80 : 70;
        chk("single_latency", lat, 7);
        chk("single_result", result, exp_val);
        @(negedge clk);
        chk("single_pulse_width", {63'd0, result_val}, 0);
        chk("single_hold", result, exp_val);
        $display("step single: latency=%0d result=%0d", lat, result);

        // Three samples with two idle cycles: 4 lanes * 3 * (2*3) = 72
        bias = 0;
        pulses_before = pulse_cnt;
        drv(64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003, 1'b1, 1'b0);
        drv(64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003, 1'b0, 1'b1);
        drv(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0);
        drv(64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003, 1'b1, 1'b0);
        drv(64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003, 1'b1, 1'b1);
        wait_pulse(lat);
        chk("multi_latency", lat, 7);
        chk("multi_result", result, 72);
        repeat (3) @(negedge clk);
        chk("multi_pulse_count", pulse_cnt - pulses_before, 1);
        chk("multi_hold", result, 72);
        $display("step multi: latency=%0d result=%0d pulses=%0d", lat, result, pulse_cnt - pulses_before);

        // Signed: -1 * 32767 = -32767, plus bias -5
        bias = -5;
        drv(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_7FFF, 1'b1, 1'b1);
        wait_pulse(lat);
        exp_val = BIAS_ON ? -32772 : -32767;
        chk("signed_latency", lat, 7);
        chk("signed_result", result, exp_val);
        @(negedge clk);
        chk("signed_pulse_width", {63'd0, result_val}, 0);
        chk("signed_hold", result, exp_val);
        $display("step signed: latency=%0d result=%0d", lat, result);

        // Back-to-back: A (70 + 10) then B (4 + 0) one cycle later
        bias = 10;
        drv(64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 1'b1, 1'b1);
        drv(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b1, 1'b1);
        wait_pulse(lat);
        chk("b2b_latency_a", lat, 6);
        chk("b2b_result_a", result, BIAS_ON ? 80 : 70);
        bias = 0;
        @(negedge clk);
        chk("b2b_val_b", {63'd0, result_val}, 1);
        chk("b2b_result_b", result, 4);
        @(negedge clk);
        chk("b2b_pulse_end", {63'd0, result_val}, 0);
        $display("step back_to_back: result_b=%0d", result);

        // Abort after two of three samples, then a fresh 1*1 window
        drv(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b1, 1'b0);
        drv(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b1, 1'b0);
        @(negedge clk);
        val = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_reset_result", result, 0);
        pulses_before = pulse_cnt;
        repeat (12) @(negedge clk);
        chk("abort_no_pulse", pulse_cnt - pulses_before, 0);
        drv(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b1, 1'b1);
        wait_pulse(lat);
        chk("abort_new_latency", lat, 7);
        chk("abort_new_result", result, 4);
        $display("step abort: latency=%0d result=%0d", lat, result);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_bias_slice.md
MAC_BIAS_SLICE -- requirements
Module: mac_bias_slice

Interface
REQ-001 The block SHALL have parameter GROUP_NB, default 4: number of parallel multiply lanes.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 16: signed image sample width.
REQ-003 The block SHALL have parameter KER_WIDTH, default 16: signed kernel weight width.
REQ-004 The block SHALL derive NUM_WIDTH = IMG_WIDTH+KER_WIDTH+1 (not overridable).
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 img  input  GROUP_NB*IMG_WIDTH  signed samples; lane g at bits [g*IMG_WIDTH +: IMG_WIDTH].
REQ-008 ker  input  GROUP_NB*KER_WIDTH  signed weights; lane g at bits [g*KER_WIDTH +: KER_WIDTH].
REQ-009 val  input  1  img/ker valid; always accepted, no backpressure.
REQ-010 last  input  1  marks the final sample of a window; qualified by val.
REQ-011 bias  input  NUM_WIDTH  signed bias, sampled at the bias-add stage.
REQ-012 result  output  NUM_WIDTH  signed window result.
REQ-013 result_val  output  1  one-cycle pulse; result is valid that cycle.

Function
REQ-014 Stage 1 SHALL register img, ker, val and last.
REQ-015 Stage 2 SHALL register, per lane, the signed product img_g*ker_g, sign-extended to NUM_WIDTH.
REQ-016 Stage 3 SHALL update the per-lane accumulator: load the product on the first sample of a window, otherwise add it.
REQ-017 The first sample of a window SHALL be the first val after rst or after a sample carrying last.
REQ-018 Cycles with val low SHALL leave accumulators unchanged; last with val low SHALL be ignored.
REQ-019 After the last sample is accumulated, the lane sums SHALL be captured into a hold register (stage 4).
REQ-020 A pipelined adder tree SHALL reduce the GROUP_NB hold values to one sum, with one register per level: clog2(GROUP_NB) cycles.
REQ-021 The bias stage SHALL register sum+bias in one cycle.
REQ-022 result_val SHALL pulse 5+clog2(GROUP_NB) cycles after the cycle where val&last is sampled at the input (7 cycles for GROUP_NB=4).
REQ-023 result SHALL hold its value until the next result_val.
REQ-024 All arithmetic SHALL be two's-complement, wrapping modulo 2^NUM_WIDTH without saturation.
REQ-025 A new window MAY start the cycle after last; pipelining SHALL keep overlapping windows independent.
REQ-026 val&last on consecutive cycles SHALL produce consecutive result_val pulses.

Reset
REQ-027 On rst, result SHALL be 0, result_val 0, accumulators 0, and all pipeline valid/last flags cleared.
REQ-028 rst mid-window or mid-drain SHALL discard in-flight data, with no result_val for it; the next val starts a fresh window.

Configuration
REQ-029 With macro MAC_BIAS_SLICE_BIAS_EN defined, the bias stage SHALL output sum+bias.
REQ-030 Without MAC_BIAS_SLICE_BIAS_EN, the bias port SHALL be ignored, the stage SHALL register sum unchanged, and latency SHALL be identical.

Structure
REQ-031 Package mac_bias_slice_pkg SHALL hold the NUM_WIDTH derivation function and the latency constant (5+clog2(GROUP_NB)).
REQ-032 The adder tree SHALL be one sub-module, sum_tree, parameterised by GROUP_NB and NUM_WIDTH.

Verification
REQ-033 Reset: assert rst 2 cycles -> result=0, result_val=0.
REQ-034 Single-sample window, GROUP_NB=4: img={1,2,3,4}, ker={5,6,7,8}, val=last=1, bias=10 -> result=80, pulsing exactly 7 cycles later.
REQ-035 Three-sample window with 2 idle cycles interleaved: img lanes all 2, ker lanes all 3, bias=0 -> result=72, one pulse.
REQ-036 Signed: lane0 img=-1, ker=32767, other lanes 0, bias=-5, single sample -> result=-32772.
REQ-037 Back-to-back windows: window A yields 80; window B, starting the next cycle with img={1,1,1,1}, ker={1,1,1,1}, bias=0 -> result=4, uncontaminated by A.
REQ-038 rst after 2 of 3 samples, then a new single-sample window with all lanes 1*1, bias=0 -> no pulse for the aborted window, then result=4.
